// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Two-requester round-robin arbiter driving a single APB master
//               port (IDLE -> SETUP -> ACCESS). Includes an ACCESS wait-state
//               timeout that aborts the transfer with an error.
// Ports       : HCLK, HRESET (async, active high)
//               REQ/REQ_WRITE/REQ_ADDR/REQ_WDATA : requester side (2 ports,
//                   32-bit lanes packed [32k+31:32k])
//               DONE/ERR/RDATA                   : requester completion
//               PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR : APB
// Parameters  : TIMEOUT - max ACCESS cycles before abort (legal 1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_WRITE,
    input  logic [63:0] REQ_ADDR,
    input  logic [63:0] REQ_WDATA,
    output logic [1:0]  DONE,
    output logic [1:0]  ERR,
    output logic [31:0] RDATA,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Wait-counter value seen in the last permitted ACCESS cycle
    localparam logic [7:0] C_LAST_CNT = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_ptr;      // preferred requester
    logic        r_owner;    // requester owning the current transfer
    logic [7:0]  r_cnt;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic [31:0] r_rdata;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    logic [1:0]  w_elig;
    logic        w_grant_valid;
    logic        w_grant_k;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // A requester whose DONE is pulsing this cycle is masked so it cannot be
    // re-granted on a REQ it has not yet had the chance to drop.
    assign w_elig        = REQ & ~r_done;
    assign w_grant_valid = |w_elig;
    assign w_grant_k     = (w_elig == 2'b11) ? r_ptr : w_elig[1];
    assign w_sel_addr    = w_grant_k ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
    assign w_sel_wdata   = w_grant_k ? REQ_WDATA[63:32] : REQ_WDATA[31:0];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_cnt     <= 8'd0;
            r_done    <= 2'b00;
            r_err     <= 2'b00;
            r_rdata   <= 32'd0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
        end else begin
            // DONE/ERR are single-cycle pulses
            r_done <= 2'b00;
            r_err  <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state   <= ST_SETUP;
                        r_owner   <= w_grant_k;
                        r_ptr     <= ~w_grant_k;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_paddr   <= w_sel_addr;
                        r_pwdata  <= w_sel_wdata;
                        r_pwrite  <= REQ_WRITE[w_grant_k];
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= 8'd0;
                end
                ST_ACCESS: begin
                    // PREADY is checked first so a ready in the final
                    // permitted cycle completes normally.
                    if (PREADY) begin
                        r_state          <= ST_IDLE;
                        r_psel           <= 1'b0;
                        r_penable        <= 1'b0;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= PSLVERR;
                        if (!r_pwrite && !PSLVERR) begin
                            r_rdata <= PRDATA;
                        end
                    end else if (r_cnt == C_LAST_CNT) begin
                        r_state          <= ST_IDLE;
                        r_psel           <= 1'b0;
                        r_penable        <= 1'b0;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign DONE    = r_done;
    assign ERR     = r_err;
    assign RDATA   = r_rdata;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Self-checking bench for apb_master_arbiter (TIMEOUT = 4).
//               Table of single transfers plus hand-written contention and
//               reset-mid-transfer sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    logic        clk;
    logic        HRESET;
    logic [1:0]  REQ;
    logic [1:0]  REQ_WRITE;
    logic [63:0] REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [1:0]  DONE;
    logic [1:0]  ERR;
    logic [31:0] RDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_arbiter #(.TIMEOUT(4)) dut (
        .HCLK      (clk),
        .HRESET    (HRESET),
        .REQ       (REQ),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .DONE      (DONE),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        k;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;      // ACCESS cycles with PREADY=0 before PREADY=1
        logic        slverr;
        logic        drop;       // drop REQ right after SETUP
        int          exp_acc;    // expected number of ACCESS cycles
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    vec_t        v;
    int          ki;
    int          n;
    bit          fin;
    logic [1:0]  exp_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin #200000; $display("FAIL watchdog actual=timeout required=finish"); $fatal(1); end

    initial begin
        //                k     wr    addr          wdata         prdata        waits slverr drop acc err   rdata
        vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_0001, 32'h0,         0,   1'b0, 1'b0, 1, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h1111_1111, 32'h1234_5678, 3,   1'b0, 1'b0, 4, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_3000, 32'h2222_2222, 32'h0000_DEAD, 0,   1'b1, 1'b0, 1, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_4000, 32'h3333_3333, 32'hAAAA_5555, 255, 1'b0, 1'b0, 4, 1'b1, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_5000, 32'h4444_4444, 32'h5555_5555, 2,   1'b0, 1'b1, 3, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_6000, 32'h5555_5555, 32'h0BAD_F00D, 1,   1'b0, 1'b0, 2, 1'b0, 32'h0BAD_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_7000, 32'h6666_6666, 32'h7777_7777, 0,   1'b1, 1'b0, 1, 1'b1, 32'h0BAD_F00D};

        HRESET    = 1'b1;
        REQ       = 2'b00;
        REQ_WRITE = 2'b00;
        REQ_ADDR  = 64'd0;
        REQ_WDATA = 64'd0;
        PRDATA    = 32'd0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        tick();
        tick();
        chk("rst_psel",    32'(PSEL),    32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite",  32'(PWRITE),  32'd0);
        chk("rst_paddr",   PADDR,        32'd0);
        chk("rst_pwdata",  PWDATA,       32'd0);
        chk("rst_rdata",   RDATA,        32'd0);
        chk("rst_done",    32'(DONE),    32'd0);
        chk("rst_err",     32'(ERR),     32'd0);
        HRESET = 1'b0;
        tick();
        chk("idle_psel", 32'(PSEL), 32'd0);

        // ---------------- table-driven single transfers ----------------
        for (int i = 0; i < NV; i++) begin
            v  = vecs[i];
            ki = int'(v.k);
            exp_done = v.k ? 2'b10 : 2'b01;
            REQ_ADDR[32*ki +: 32]  = v.addr;
            REQ_WDATA[32*ki +: 32] = v.wdata;
            REQ_WRITE[ki] = v.wr;
            REQ[ki]       = 1'b1;
            PRDATA        = v.prdata;
            PSLVERR       = v.slverr;
            PREADY        = 1'b0;
            tick();
            chk("setup_pstate", {30'd0, PSEL, PENABLE}, 32'b10);
            chk("setup_paddr",  PADDR,  v.addr);
            chk("setup_pwdata", PWDATA, v.wdata);
            chk("setup_pwrite", 32'(PWRITE), 32'(v.wr));
            chk("setup_done",   32'(DONE), 32'd0);
            if (v.drop) REQ[ki] = 1'b0;
            tick();
            chk("access_pstate", {30'd0, PSEL, PENABLE}, 32'b11);
            n   = 0;
            fin = 1'b0;
            while (!fin && n < 40) begin
                PREADY = (n == v.waits);
                tick();
                if (PENABLE) n++;
                else fin = 1'b1;
            end
            chk("access_cycles", 32'(n + 1), 32'(v.exp_acc));
            chk("done_pulse",  32'(DONE), 32'(exp_done));
            chk("err_status",  32'(ERR),  v.exp_err ? 32'(exp_done) : 32'd0);
            chk("rdata",       RDATA,     v.exp_rdata);
            chk("done_pstate", {30'd0, PSEL, PENABLE}, 32'b00);
            REQ[ki] = 1'b0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            tick();
            chk("done_clear",  32'(DONE), 32'd0);
            chk("idle_psel",   32'(PSEL), 32'd0);
            chk("idle_hold_paddr", PADDR, v.addr);
        end

        // ---------------- reset in the middle of ACCESS ----------------
        // Requester 0 granted here leaves the pointer preferring 1, so a
        // requester-0-first order afterwards shows the pointer was reset.
        REQ_ADDR[31:0] = 32'h0000_8000;
        REQ_WRITE      = 2'b11;
        REQ            = 2'b01;
        PREADY         = 1'b0;
        tick();
        tick();
        chk("rst_mid_access", {30'd0, PSEL, PENABLE}, 32'b11);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_async_psel",  32'(PSEL),    32'd0);
        chk("rst_async_pen",   32'(PENABLE), 32'd0);
        chk("rst_async_rdata", RDATA,        32'd0);
        REQ = 2'b00;
        tick();
        chk("rst_no_done", 32'(DONE), 32'd0);
        HRESET = 1'b0;

        // ---------------- contention, both requesting ----------------
        REQ_ADDR  = {32'h0000_B000, 32'h0000_A000};
        REQ_WDATA = {32'hBBBB_0000, 32'hAAAA_0000};
        REQ       = 2'b11;
        PREADY    = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("cont_setup", {30'd0, PSEL, PENABLE}, 32'b10);
            chk("cont_paddr", PADDR, (g % 2 == 1) ? 32'h0000_B000 : 32'h0000_A000);
            chk("cont_nodone", 32'(DONE), 32'd0);
            tick();
            chk("cont_access", {30'd0, PSEL, PENABLE}, 32'b11);
            tick();
            chk("cont_done", 32'(DONE), (g % 2 == 1) ? 32'b10 : 32'b01);
            chk("cont_err",  32'(ERR),  32'd0);
        end
        REQ    = 2'b00;
        PREADY = 1'b0;
        tick();
        chk("cont_end_idle", {30'd0, PSEL, PENABLE}, 32'b00);
        chk("cont_end_done", 32'(DONE), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 The block SHALL have parameter `TIMEOUT`, default 16, which sets the maximum number of ACCESS cycles before abort; the legal range is 1..255.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- `HCLK`  in  1  single clock; all state updates on the rising edge.
- `HRESET`  in  1  asynchronous, active-high reset.
- `REQ`  in  2  transfer request, one bit per requester `k` (0, 1).
- `REQ_WRITE`  in  2  per requester: 1 = write, 0 = read.
- `REQ_ADDR`  in  64  per requester address; requester `k` uses bits `[32k+31:32k]`.
- `REQ_WDATA`  in  64  per requester write data, same packing as `REQ_ADDR`.
- `DONE`  out  2  one-cycle completion pulse to requester `k`.
- `ERR`  out  2  error status, valid only while `DONE[k]` = 1.
- `RDATA`  out  32  read data from the last successful read.
- `PSEL`  out  1  APB select.
- `PENABLE`  out  1  APB enable.
- `PWRITE`  out  1  APB direction.
- `PADDR`  out  32  APB address.
- `PWDATA`  out  32  APB write data.
- `PRDATA`  in  32  APB read data.
- `PREADY`  in  1  APB ready.
- `PSLVERR`  in  1  APB slave error.
REQ-003 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Function
REQ-004 The block SHALL implement an FSM with three states:
- IDLE (`PSEL`=0, `PENABLE`=0)
- SETUP (`PSEL`=1, `PENABLE`=0)
- ACCESS (`PSEL`=1, `PENABLE`=1)
REQ-005 A requester `k` SHALL be eligible in IDLE when `REQ[k]`=1 and `DONE[k]`=0 in that cycle; a requester is therefore never re-granted in the cycle its DONE pulses.
REQ-006 Arbitration SHALL be round-robin using a 1-bit priority pointer:
- Reset value 0, meaning requester 0 is preferred.
- If both requesters are eligible, the preferred one wins.
- If only one is eligible, it wins regardless of the pointer.
- After any grant, the pointer SHALL point to the non-granted requester.
REQ-007 On a grant in IDLE, the block SHALL go to SETUP on the next edge and load the winner's address, write data and direction into `PADDR`/`PWDATA`/`PWRITE` at that same edge.
REQ-008 From SETUP, the block SHALL go unconditionally to ACCESS after exactly one cycle.
REQ-009 In ACCESS with `PREADY`=1, at the next edge the block SHALL:
- return to IDLE;
- pulse `DONE[k]`=1 for one cycle, with `ERR[k]`=`PSLVERR`;
- if it was a read and `PSLVERR`=0, load `RDATA` with `PRDATA`.
REQ-010 `RDATA` SHALL hold its value otherwise, including on writes, errored reads and timeouts.
REQ-011 The wait counter SHALL be 8 bits, cleared on entry to ACCESS, and incremented on each ACCESS cycle with `PREADY`=0.
REQ-012 On timeout (ACCESS, `PREADY`=0, counter = `TIMEOUT`-1), at the next edge the block SHALL return to IDLE and pulse `DONE[k]`=1 with `ERR[k]`=1, leaving `RDATA` unchanged. ACCESS therefore lasts at most `TIMEOUT` cycles.
REQ-013 If `PREADY`=1 in the final permitted ACCESS cycle, normal completion (REQ-009) SHALL take precedence over timeout.
REQ-014 A requester SHALL hold `REQ` and its operands stable until it sees `DONE`. If `REQ` drops mid-transfer, the transfer SHALL still complete and `DONE` SHALL still pulse.
REQ-015 `PADDR`, `PWDATA` and `PWRITE` SHALL hold their last values in IDLE.
REQ-016 `DONE` SHALL be one-hot or zero; both bits SHALL never be high together.
REQ-017 The minimum transfer SHALL take 3 cycles (SETUP, ACCESS, IDLE). Back-to-back alternating grants SHALL sustain one transfer per 3 cycles.

Reset
REQ-018 While `HRESET`=1, asynchronously, the block SHALL set:
- state = IDLE, priority pointer = 0, wait counter = 0;
- `PSEL`=0, `PENABLE`=0, `PWRITE`=0;
- `PADDR`=0, `PWDATA`=0, `RDATA`=0;
- `DONE`=0, `ERR`=0.
REQ-019 A reset asserted mid-transfer SHALL abort that transfer with no `DONE` pulse. After release, arbitration SHALL restart with requester 0 preferred.

Verification
REQ-020 Single write:
- Stimulus: `REQ`=01, `ADDR0`=0x1000, `WDATA0`=0xCAFE0001, `PREADY`=1.
- Response: SETUP at cycle 1 with `PADDR`=0x1000, `PWRITE`=1; ACCESS at cycle 2; `DONE`=01, `ERR`=00 at cycle 3.
REQ-021 Read with wait states:
- Stimulus: `REQ`=10, `PREADY` low for 3 ACCESS cycles, `PRDATA`=0x12345678.
- Response: `DONE`=10 after the 4th ACCESS cycle; `RDATA`=0x12345678.
REQ-022 Contention:
- Stimulus: `REQ`=11 held continuously, `PREADY`=1.
- Response: grant order 0,1,0,1; `DONE` pulses every 3 cycles, alternating.
REQ-023 Timeout:
- Stimulus: `TIMEOUT`=4, `PREADY`=0 forever.
- Response: exactly 4 ACCESS cycles, then `DONE[k]`=1, `ERR[k]`=1, `RDATA` unchanged.
- Repeat with `PREADY`=1 in the 4th ACCESS cycle: `ERR`=0.
REQ-024 Slave error:
- Stimulus: read with `PSLVERR`=1, `PRDATA`=0xDEAD.
- Response: `ERR[k]`=1; `RDATA` keeps its prior value.
REQ-025 Reset mid-ACCESS:
- Stimulus: `HRESET` pulse.
- Response: `PSEL`=0 immediately; no `DONE`; with `REQ`=11 after release, requester 0 is granted first.
